// File: rtl/mem_pkg.sv
// Shared types for the data-memory path: access-size encoding, responder
// FSM states and the alignment rule used to flag bad requests.
package mem_pkg;

    typedef enum logic [1:0] {
        DT_WORD = 2'b00,
        DT_BYTE = 2'b01,
        DT_HALF = 2'b10,
        DT_RSVD = 2'b11
    } data_type_t;

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t IDLE  = 2'd0;
    localparam dmem_state_t WAIT  = 2'd1;
    localparam dmem_state_t WRITE = 2'd2;
    localparam dmem_state_t RESP  = 2'd3;

    // Reserved type or a size not aligned to its own width is an error.
    function automatic logic access_error(input data_type_t dtype, input logic [1:0] lane);
        case (dtype)
            DT_WORD: return lane != 2'b00;
            DT_HALF: return lane[0];
            DT_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_byte_lane_unit.sv
// Little-endian lane logic: extracts and extends sub-word load data and
// merges sub-word store data into a read word. Purely combinational.
module byte_lane_unit
    import mem_pkg::*;
(
    input  data_type_t  dtype,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_bit;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        load_data   = '0;
        merged_word = rd_word;
        sel_byte    = rd_word[{lane, 3'b000} +: 8];
        sel_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        sign_bit    = 1'b0;
        case (dtype)
            DT_WORD: begin
                load_data   = rd_word;
                merged_word = wr_data;
            end
            DT_BYTE: begin
                sign_bit    = ~is_unsigned & sel_byte[7];
                load_data   = {{24{sign_bit}}, sel_byte};
                merged_word[{lane, 3'b000} +: 8] = wr_data[7:0];
            end
            DT_HALF: begin
                sign_bit  = ~is_unsigned & sel_half[15];
                load_data = {{16{sign_bit}}, sel_half};
                if (lane[1]) merged_word[31:16] = wr_data[15:0];
                else         merged_word[15:0]  = wr_data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core's load/store path: one request at a time, word or
// sub-word access with read-modify-write for partial stores.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 17,
    parameter int Data_Width   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_type,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [Data_Width-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [Data_Width-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int         DEPTH     = 1 << (ADDR_WIDTH - 2);
    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    logic [Data_Width-1:0] mem [DEPTH];
    logic [Data_Width-1:0] rd_word_q;

    dmem_state_t           state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    data_type_t            type_q, type_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [Data_Width-1:0] wdata_q, wdata_d;
    logic [Data_Width-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  accept;
    logic                  mem_we;
    logic [Data_Width-1:0] load_data;
    logic [Data_Width-1:0] merged_word;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_valid & req_ready;

    byte_lane_unit u_lanes (
        .dtype       (type_q),
        .lane        (addr_q[1:0]),
        .is_unsigned (uns_q),
        .rd_word     (rd_word_q),
        .wr_data     (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        type_d      = type_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    type_d  = data_type_t'(req_type);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (access_error(data_type_t'(req_type), req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && data_type_t'(req_type) == DT_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    if (we_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d     = RESP;
                        rsp_rdata_d = load_data;
                        rsp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WRITE: begin
                mem_we      = 1'b1;
                state_d     = RESP;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            default: begin
                if (rsp_ready) state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            type_q      <= DT_WORD;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            type_q      <= type_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the array and its read register have no reset so they map onto
    // plain RAM; a write in flight when rst rises may still land.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[ADDR_WIDTH-1:2]] <= merged_word;
        // The word is fetched at accept; WAIT models the array's read delay.
        if (accept) rd_word_q <= mem[req_addr[ADDR_WIDTH-1:2]];
    end

endmodule
